// File: rtl/regfile_pkg.sv
// Shared register-file parameters and the posted-write entry type
// used by the write buffer and its forwarding logic.
package regfile_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage : regfile_pkg

// File: rtl/wb_fwd_match.sv
// Per-read-port forwarding select: returns the data of the newest valid
// pending write to rd_addr, or the register-file value when none matches.
module wb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]         entry_addr [DEPTH],
  input  logic [DATA_W-1:0]         entry_data [DEPTH],
  input  logic [DEPTH-1:0]          valid,
  input  logic [$clog2(DEPTH)-1:0]  wr_ptr,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         rf_data,
  output logic [DATA_W-1:0]         fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] slot_hit;
  logic [DEPTH-1:0] age_hit;
  logic [PTR_W-1:0] age_slot [DEPTH];

  // age_slot[0] is the slot written most recently (just behind wr_ptr).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign slot_hit[gi] = valid[gi] & (entry_addr[gi] == rd_addr);
      assign age_slot[gi] = wr_ptr - PTR_W'(gi + 1);
      assign age_hit[gi]  = slot_hit[age_slot[gi]];
    end
  endgenerate

  // Walk oldest to newest so the newest hit is the last one assigned.
  always_comb begin
    fwd_data = rf_data;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (age_hit[k]) begin
        fwd_data = entry_data[age_slot[k]];
      end
    end
  end

endmodule : wb_fwd_match

// File: rtl/regfile_write_buffer.sv
// Posted-write FIFO in front of the register file: queues execute-stage
// writes, drains one per cycle, and forwards pending data to both read ports.
module regfile_write_buffer
  import regfile_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     drain_en,
  output logic [DATA_W-1:0]        rf_Din,
  output logic                     rf_writeEn,
  output logic [ADDR_W-1:0]        rf_writeAdd,
  input  logic [ADDR_W-1:0]        read1Add,
  input  logic [ADDR_W-1:0]        read2Add,
  input  logic [DATA_W-1:0]        rf_Dout1,
  input  logic [DATA_W-1:0]        rf_Dout2,
  output logic [DATA_W-1:0]        Dout1,
  output logic [DATA_W-1:0]        Dout2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  valid_next;
  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic              push;
  logic              drain;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign wr_ready = ~full;
  assign count    = count_reg;

  // No pass-through: a full buffer refuses even when a drain frees a slot.
  assign push  = wr_valid & wr_ready;
  assign drain = drain_en & ~empty;

  assign rf_writeEn  = drain;
  assign rf_Din      = empty ? '0 : entry_data[rd_ptr_reg];
  assign rf_writeAdd = empty ? '0 : entry_addr[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, drain})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Push and drain never target the same slot: that needs count 0 or DEPTH.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_next[gi] =
          (valid_reg[gi] & ~(drain & (rd_ptr_reg == PTR_W'(gi))))
        | (push & (wr_ptr_reg == PTR_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (drain) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      valid_reg <= valid_next;
    end
  end

  // Entry payload is never reset; valid_reg alone says what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[wr_ptr_reg] <= wr_addr;
      entry_data[wr_ptr_reg] <= wr_data;
    end
  end

  wb_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd1 (
    .entry_addr (entry_addr),
    .entry_data (entry_data),
    .valid      (valid_reg),
    .wr_ptr     (wr_ptr_reg),
    .rd_addr    (read1Add),
    .rf_data    (rf_Dout1),
    .fwd_data   (Dout1)
  );

  wb_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd2 (
    .entry_addr (entry_addr),
    .entry_data (entry_data),
    .valid      (valid_reg),
    .wr_ptr     (wr_ptr_reg),
    .rd_addr    (read2Add),
    .rf_data    (rf_Dout2),
    .fwd_data   (Dout2)
  );

endmodule : regfile_write_buffer

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: a queue scoreboard of pending
// writes predicts drains and forwarding; the bench also models the register file.
module tb_regfile_write_buffer;
  import regfile_pkg::*;

  localparam int DEPTH = WB_DEPTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [RF_ADDR_W-1:0] wr_addr;
  logic [RF_DATA_W-1:0] wr_data;
  logic                 drain_en;
  logic [RF_DATA_W-1:0] rf_Din;
  logic                 rf_writeEn;
  logic [RF_ADDR_W-1:0] rf_writeAdd;
  logic [RF_ADDR_W-1:0] read1Add;
  logic [RF_ADDR_W-1:0] read2Add;
  logic [RF_DATA_W-1:0] rf_Dout1;
  logic [RF_DATA_W-1:0] rf_Dout2;
  logic [RF_DATA_W-1:0] Dout1;
  logic [RF_DATA_W-1:0] Dout2;
  logic [2:0]           count;
  logic                 empty;
  logic                 full;

  int checks = 0;
  int errors = 0;

  wb_entry_t            exp_q[$];
  logic [RF_DATA_W-1:0] rf_mem [RF_NUM_REGS];

  always #5 clk = ~clk;

  regfile_write_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .drain_en    (drain_en),
    .rf_Din      (rf_Din),
    .rf_writeEn  (rf_writeEn),
    .rf_writeAdd (rf_writeAdd),
    .read1Add    (read1Add),
    .read2Add    (read2Add),
    .rf_Dout1    (rf_Dout1),
    .rf_Dout2    (rf_Dout2),
    .Dout1       (Dout1),
    .Dout2       (Dout2),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  // Register file model driven by the buffer's write port.
  assign rf_Dout1 = rf_mem[read1Add];
  assign rf_Dout2 = rf_mem[read2Add];
  always @(posedge clk) begin
    if (rf_writeEn) rf_mem[rf_writeAdd] <= rf_Din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_expect(input logic [RF_ADDR_W-1:0] a,
                                             input logic [31:0] fallback);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].addr == a) return exp_q[i].data;
    end
    return fallback;
  endfunction

  task automatic check_outputs(input logic de);
    int n;
    n = exp_q.size();
    chk("count",      32'(count),      32'(n));
    chk("empty",      32'(empty),      32'(n == 0));
    chk("full",       32'(full),       32'(n == DEPTH));
    chk("wr_ready",   32'(wr_ready),   32'(n != DEPTH));
    chk("rf_writeEn", 32'(rf_writeEn), 32'(de && n > 0));
    if (n > 0) begin
      chk("rf_writeAdd", 32'(rf_writeAdd), 32'(exp_q[0].addr));
      chk("rf_Din",      rf_Din,           exp_q[0].data);
    end else begin
      chk("rf_writeAdd", 32'(rf_writeAdd), 32'd0);
      chk("rf_Din",      rf_Din,           32'd0);
    end
    chk("Dout1", Dout1, fwd_expect(read1Add, rf_Dout1));
    chk("Dout2", Dout2, fwd_expect(read2Add, rf_Dout2));
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the scoreboard at the edge.
  task automatic cycle(input logic v, input logic [RF_ADDR_W-1:0] a,
                       input logic [31:0] d, input logic de);
    wb_entry_t e;
    logic      acc;
    logic      drn;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    drain_en = de;
    @(negedge clk);
    check_outputs(de);
    acc = v && (exp_q.size() < DEPTH);
    drn = de && (exp_q.size() > 0);
    @(posedge clk);
    if (drn) begin
      $display("drain addr=%0d data=%h", exp_q[0].addr, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    if (acc) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
      $display("push  addr=%0d data=%h", a, d);
    end else if (v) begin
      $display("block addr=%0d data=%h", a, d);
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < RF_NUM_REGS; i++) rf_mem[i] = '0;
    rst = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    drain_en = 1'b0;
    read1Add = '0;
    read2Add = '0;

    #1;
    chk("rst_count",      32'(count),      32'd0);
    chk("rst_empty",      32'(empty),      32'd1);
    chk("rst_full",       32'(full),       32'd0);
    chk("rst_wr_ready",   32'(wr_ready),   32'd1);
    chk("rst_rf_writeEn", 32'(rf_writeEn), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single write held off, then drained
    read1Add = 5'd7;
    read2Add = 5'd0;
    cycle(1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    chk("rf7", rf_mem[7], 32'hDEADBEEF);

    // Same-address priority and ordered drain
    read1Add = 5'd7;
    read2Add = 5'd3;
    cycle(1'b1, 5'd3, 32'h11111111, 1'b0);
    cycle(1'b1, 5'd3, 32'h22222222, 1'b0);
    cycle(1'b1, 5'd3, 32'h33333333, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 1'b1);
    chk("rf3", rf_mem[3], 32'h33333333);

    // Full boundary: blocked fifth write, also blocked while draining
    read1Add = 5'd9;
    read2Add = 5'd13;
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(10 + i), 32'hF0 + 32'(i), 1'b0);
    cycle(1'b1, 5'd9, 32'h55, 1'b0);
    cycle(1'b1, 5'd9, 32'h55, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 1'b1);
    chk("rf9_unwritten", rf_mem[9], 32'h0);
    chk("rf13", rf_mem[13], 32'hF3);

    // Push and drain together at count 1
    read1Add = 5'd1;
    read2Add = 5'd2;
    cycle(1'b1, 5'd1, 32'hA, 1'b0);
    cycle(1'b1, 5'd2, 32'hB, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    chk("rf1", rf_mem[1], 32'hA);
    chk("rf2", rf_mem[2], 32'hB);

    // Pointer wrap: streaming writes with continuous drain
    for (int i = 0; i < 10; i++) begin
      read1Add = 5'(i);
      read2Add = 5'(i + 1);
      cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) chk("wrap_rf", rf_mem[i], 32'h100 + 32'(i));

    // Asynchronous reset with three writes pending
    read1Add = 5'd20;
    read2Add = 5'd21;
    cycle(1'b1, 5'd20, 32'hC0DE0020, 1'b0);
    cycle(1'b1, 5'd21, 32'hC0DE0021, 1'b0);
    cycle(1'b1, 5'd22, 32'hC0DE0022, 1'b0);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    drain_en = 1'b1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_count",      32'(count),      32'd0);
    chk("mid_rst_empty",      32'(empty),      32'd1);
    chk("mid_rst_wr_ready",   32'(wr_ready),   32'd1);
    chk("mid_rst_rf_writeEn", 32'(rf_writeEn), 32'd0);
    for (int i = 0; i < RF_NUM_REGS; i++) begin
      read1Add = 5'(i);
      #1;
      chk("rst_Dout1", Dout1, rf_Dout1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain_en = 1'b0;
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    chk("rf20_discarded", rf_mem[20], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_write_buffer
